// File: rtl/pci_target_ctrl_if.sv
// Target-side PCI handshake bundle: bus-cycle inputs from the master/decoder/buffer
// and the DEVSEL#/TRDY#/STOP# response plus beat reporting back out.
interface pci_target_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             frame_n;
    logic             irdy_n;
    logic             addr_hit;
    logic             cmd_rd;
    logic             buf_ready;
    logic             devsel_n;
    logic             trdy_n;
    logic             stop_n;
    logic             ad_oe;
    logic             xfer;
    logic [CNT_W-1:0] beat_cnt;

    modport slave (
        input  frame_n, irdy_n, addr_hit, cmd_rd, buf_ready,
        output devsel_n, trdy_n, stop_n, ad_oe, xfer, beat_cnt
    );

    modport master (
        output frame_n, irdy_n, addr_hit, cmd_rd, buf_ready,
        input  devsel_n, trdy_n, stop_n, ad_oe, xfer, beat_cnt
    );
endinterface

// File: rtl/pci_target_ctrl.sv
// PCI target bus-cycle sequencer: claims decoded frames after a programmable devsel
// delay, paces data beats on local buffer readiness, and disconnects on burst/wait limits.
module pci_target_ctrl #(
    parameter int DEVSEL_DLY = 1,
    parameter int MAX_BURST  = 8,
    parameter int WAIT_MAX   = 8,
    parameter int CNT_W      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pci_target_ctrl_if.slave    bus
);
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_DATA, S_DISC, S_TURN} state_e;

    localparam int               WW         = $clog2(WAIT_MAX + 1);
    localparam logic [1:0]       DLY_LAST   = 2'(DEVSEL_DLY - 1);
    localparam logic [WW-1:0]    WAIT_LAST  = WW'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] BURST_MAX  = CNT_W'(MAX_BURST);

    state_e           state_q, state_d;
    logic             frame_prev_q;
    logic             rd_q, rd_d;
    logic [1:0]       dly_q, dly_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             xfer_q, xfer_d;
    logic             devsel_n, trdy_n, stop_n, ad_oe;
    logic             addr_phase, beat;

    // Address phase is a FRAME# falling edge, only recognised from IDLE.
    assign addr_phase = (state_q == S_IDLE) && !bus.frame_n && frame_prev_q;
    assign beat       = (state_q == S_DATA) && !bus.irdy_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            frame_prev_q <= 1'b1;
            rd_q         <= 1'b0;
            dly_q        <= '0;
            wait_q       <= '0;
            cnt_q        <= '0;
            xfer_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_prev_q <= bus.frame_n;
            rd_q         <= rd_d;
            dly_q        <= dly_d;
            wait_q       <= wait_d;
            cnt_q        <= cnt_d;
            xfer_q       <= xfer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        dly_d   = dly_q;
        wait_d  = '0;
        cnt_d   = cnt_q;
        xfer_d  = beat;
        case (state_q)
            S_IDLE: begin
                if (addr_phase) begin
                    cnt_d = '0;
                    rd_d  = bus.cmd_rd;
                    dly_d = '0;
                    if (bus.addr_hit) state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Reads always spend a WAIT cycle for AD turnaround; writes may skip it.
                if (dly_q == DLY_LAST)
                    state_d = (!rd_q && bus.buf_ready) ? S_DATA : S_WAIT;
                else
                    dly_d = dly_q + 1'b1;
            end
            S_WAIT: begin
                if (bus.buf_ready)          state_d = S_DATA;
                else if (wait_q == WAIT_LAST) state_d = S_DISC;
                else                        wait_d  = wait_q + 1'b1;
            end
            S_DATA: begin
                if (!bus.irdy_n) begin
                    cnt_d = (cnt_q == BURST_MAX) ? cnt_q : cnt_q + 1'b1;
                    // Last beat outranks burst limit, so no STOP# on a natural end.
                    if (bus.frame_n)              state_d = S_TURN;
                    else if (cnt_q == BURST_LAST) state_d = S_DISC;
                    else if (!bus.buf_ready)      state_d = S_WAIT;
                end
            end
            S_DISC:  if (bus.frame_n) state_d = S_TURN;
            S_TURN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        devsel_n = 1'b1;
        trdy_n   = 1'b1;
        stop_n   = 1'b1;
        ad_oe    = 1'b0;
        case (state_q)
            S_WAIT: begin
                devsel_n = 1'b0;
                ad_oe    = rd_q;
            end
            S_DATA: begin
                devsel_n = 1'b0;
                trdy_n   = 1'b0;
                ad_oe    = rd_q;
            end
            S_DISC: begin
                devsel_n = 1'b0;
                stop_n   = 1'b0;
                ad_oe    = rd_q;
            end
            default: ;
        endcase
    end

    assign bus.devsel_n = devsel_n;
    assign bus.trdy_n   = trdy_n;
    assign bus.stop_n   = stop_n;
    assign bus.ad_oe    = ad_oe;
    assign bus.xfer     = xfer_q;
    assign bus.beat_cnt = cnt_q;

endmodule
